// File: rtl/sevenseg_capture.sv
// Monitors a multiplexed active-low seven-segment bus and rebuilds the eight displayed hex digits.
// Each stable anode dwell yields one capture; a scan wrap or an idle timeout publishes the frame.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  sevenSeg,
  output logic [31:0] digits,
  output logic [7:0]  present,
  output logic [7:0]  seg_err,
  output logic        frame_valid,
  output logic        multi_an
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [9:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] buf_dig_q, buf_dig_d;
  logic [7:0]  buf_pres_q, buf_pres_d;
  logic [7:0]  buf_err_q, buf_err_d;
  logic [2:0]  last_p_q, last_p_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic [3:0]  n_low;
  logic [2:0]  samp_p;
  logic        single, multi;
  logic [9:0]  samp;
  logic        load, cap, publish;
  logic [3:0]  dec_nib;
  logic        dec_err;
  int          idx;

  // Position p is driven by an[7-p].
  always_comb begin
    n_low  = 4'd0;
    samp_p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) begin
        n_low  = n_low + 4'd1;
        samp_p = 3'(7 - i);
      end
    end
    single = (n_low == 4'd1);
    multi  = (n_low > 4'd1);
    samp   = {samp_p, sevenSeg};
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: load = single;
      TRACK: begin
        if (!single) begin
          state_d = IDLE;
        end else if (samp == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(STABLE_CYCLES)) begin
            cap     = 1'b1;
            state_d = HELD;
          end
        end else begin
          load = 1'b1;
        end
      end
      HELD: begin
        if (!single)              state_d = IDLE;
        else if (samp != cand_q)  load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cand_d = samp;
      cnt_d  = 4'd1;
      if (STABLE_CYCLES == 1) begin
        cap     = 1'b1;
        state_d = HELD;
      end else begin
        state_d = TRACK;
      end
    end
  end

  always_comb begin
    dec_err = 1'b0;
    case (sevenSeg)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    buf_dig_d  = buf_dig_q;
    buf_pres_d = buf_pres_q;
    buf_err_d  = buf_err_q;
    last_p_d   = last_p_q;
    tcnt_d     = tcnt_q;
    publish    = 1'b0;
    idx        = 7 - int'(samp_p);
    if (cap) begin
      // A capture at or before the previous position means the scan wrapped.
      if (buf_pres_q != 8'h00 && samp_p <= last_p_q) begin
        publish    = 1'b1;
        buf_dig_d  = 32'h0;
        buf_pres_d = 8'h00;
        buf_err_d  = 8'h00;
      end
      buf_dig_d[4*idx +: 4] = dec_nib;
      buf_pres_d[idx]       = 1'b1;
      buf_err_d[idx]        = dec_err;
      last_p_d              = samp_p;
      tcnt_d                = 16'd0;
    end else begin
      if (tcnt_q != 16'(TIMEOUT)) tcnt_d = tcnt_q + 16'd1;
      if (tcnt_d == 16'(TIMEOUT) && buf_pres_q != 8'h00) begin
        publish    = 1'b1;
        buf_dig_d  = 32'h0;
        buf_pres_d = 8'h00;
        buf_err_d  = 8'h00;
        last_p_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      buf_dig_q   <= '0;
      buf_pres_q  <= '0;
      buf_err_q   <= '0;
      last_p_q    <= '0;
      tcnt_q      <= '0;
      digits      <= '0;
      present     <= '0;
      seg_err     <= '0;
      frame_valid <= 1'b0;
      multi_an    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      buf_dig_q   <= buf_dig_d;
      buf_pres_q  <= buf_pres_d;
      buf_err_q   <= buf_err_d;
      last_p_q    <= last_p_d;
      tcnt_q      <= tcnt_d;
      frame_valid <= publish;
      multi_an    <= multi;
      if (publish) begin
        digits  <= buf_dig_q;
        present <= buf_pres_q;
        seg_err <= buf_err_q;
      end
    end
  end

endmodule
